// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start bit, DATA_BITS data bits LSB first, one stop bit).
//
// Ports
//   clk            sole clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   baud_tick      one-clk strobe at 16x the baud rate
//   rx             asynchronous serial input, idles high
//   data_out       last received data word, updated only when a frame completes
//   data_valid     one-clk pulse: frame completed with a good (high) stop bit
//   framing_error  one-clk pulse: frame completed with a low stop bit
//   busy           high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  // Elaboration-time parameter guards.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gen_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..8");
  end
  if (OVERSAMPLE != 16) begin : gen_bad_oversample
    $error("uart_rx: OVERSAMPLE must be 16");
  end

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Mid-bit of the start bit, and the last tick of a full bit period.
  localparam logic [3:0] TickMid  = 4'd7;
  localparam logic [3:0] TickLast = 4'd15;
  localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

  // Two-flop synchronizer; both flops reset to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  logic rx_meta_q;
  logic rx_sync_q;

  state_e               state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= StIdle;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Start edge is acted on immediately, independent of baud_tick.
        if (!rx_sync_q) begin
          state_d = StStart;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end
      end

      StStart: begin
        if (baud_tick) begin
          if (tcnt_q == TickMid) begin
            tcnt_d  = '0;
            // A line back high at mid start bit was a glitch, not a frame.
            state_d = rx_sync_q ? StIdle : StData;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      StData: begin
        if (baud_tick) begin
          // Counting from mid start bit, tcnt wrapping from 15 lands on mid data bit.
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == TickLast) begin
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == BitLast) begin
              state_d = StStop;
            end
          end
        end
      end

      StStop: begin
        if (baud_tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == TickLast) begin
            data_d  = shift_q;
            valid_d = rx_sync_q;
            ferr_d  = !rx_sync_q;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (8-bit instance plus a 7-bit instance).
// Expected results come from frame-level rules: every transmitted frame yields exactly one
// event, data_valid if its stop bit is high or framing_error if low, carrying its data word.
module tb_uart_rx;

  typedef struct packed {
    logic       dv;
    logic       fe;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_dv;
    logic       exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  localparam int BitClk = 64;  // 16 ticks per bit, one tick every 4 clk

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       tick_en;
  logic [1:0] tick_div;
  logic       rx_line;
  logic       sel7;
  logic       rx8;
  logic       rx7;

  logic [7:0] data_out8;
  logic       dv8;
  logic       fe8;
  logic       busy8;
  logic [6:0] data_out7;
  logic       dv7;
  logic       fe7;
  logic       busy7;

  int n_pass;
  int n_total;
  ev_t ev_q[$];
  ev_t exp_q[$];
  vec_t vecs[8];
  int t55;
  int t7;
  int dv7_cnt;
  int fe7_cnt;

  assign rx8 = sel7 ? 1'b1 : rx_line;
  assign rx7 = sel7 ? rx_line : 1'b1;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx8),
    .data_out      (data_out8),
    .data_valid    (dv8),
    .framing_error (fe8),
    .busy          (busy8)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx7),
    .data_out      (data_out7),
    .data_valid    (dv7),
    .framing_error (fe7),
    .busy          (busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud strobe: one clk high every 4 clk while enabled.
  initial begin
    baud_tick = 1'b0;
    tick_div  = 2'd0;
    forever begin
      @(negedge clk);
      tick_div  = tick_div + 2'd1;
      baud_tick = tick_en && (tick_div == 2'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Record every output pulse of the 8-bit receiver.
  always @(negedge clk) begin
    if (dv8 || fe8) begin
      ev_q.push_back('{dv: dv8, fe: fe8, data: data_out8});
      check("pulse exclusive", 32'(dv8 & fe8), 32'd0);
    end
  end

  function automatic ev_t model_frame(input logic [7:0] d, input logic stop);
    ev_t e;
    e.dv   = stop;
    e.fe   = !stop;
    e.data = d;
    return e;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Low stop bits are released early so the receiver's restart on the still-low line
  // resolves cleanly as a false start.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    rx_line = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < nbits; i++) begin
      rx_line = d[i];
      wait_clk(BitClk);
    end
    if (stop) begin
      rx_line = 1'b1;
      wait_clk(BitClk);
    end else begin
      rx_line = 1'b0;
      wait_clk(40);
      rx_line = 1'b1;
      wait_clk(BitClk - 40);
    end
  endtask

  task automatic compare_events(input string tag);
    check($sformatf("%s event count", tag), 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      check($sformatf("%s ev%0d dv", tag, i), 32'(ev_q[i].dv), 32'(exp_q[i].dv));
      check($sformatf("%s ev%0d fe", tag, i), 32'(ev_q[i].fe), 32'(exp_q[i].fe));
      check($sformatf("%s ev%0d data", tag, i), 32'(ev_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    t55     = 0;
    t7      = 0;
    dv7_cnt = 0;
    fe7_cnt = 0;
    tick_en = 1'b1;
    sel7    = 1'b0;
    rx_line = 1'b1;
    rst     = 1'b1;

    vecs[0] = '{8'hA3, 1'b1, 0,  1'b1, 1'b0, 8'hA3};
    vecs[1] = '{8'h0F, 1'b1, 64, 1'b1, 1'b0, 8'h0F};
    vecs[2] = '{8'hC6, 1'b0, 64, 1'b0, 1'b1, 8'hC6};
    vecs[3] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 32, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'h80, 1'b0, 80, 1'b0, 1'b1, 8'h80};
    vecs[6] = '{8'h01, 1'b1, 0,  1'b1, 1'b0, 8'h01};
    vecs[7] = '{8'h7E, 1'b1, 64, 1'b1, 1'b0, 8'h7E};

    // Reset state.
    wait_clk(5);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst data_valid", 32'(dv8), 32'd0);
    check("rst framing_error", 32'(fe8), 32'd0);
    check("rst data_out", 32'(data_out8), 32'd0);

    // Reset wins over a low line and running ticks.
    rx_line = 1'b0;
    wait_clk(40);
    check("rst priority busy", 32'(busy8), 32'd0);
    rx_line = 1'b1;
    rst = 1'b0;
    wait_clk(6);
    check("post-rst idle", 32'(busy8), 32'd0);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;

    // 0x55 right after reset release, with latency to the data_valid pulse.
    ev_q.delete();
    exp_q.delete();
    exp_q.push_back(model_frame(8'h55, 1'b1));
    fork
      send_frame(8'h55, 1'b1, 8);
      begin
        for (int c = 1; c <= 700; c++) begin
          @(negedge clk);
          if (dv8 && t55 == 0) t55 = c;
        end
      end
    join
    check_range("0x55 dv latency", t55, 608, 611);
    check("0x55 data_out", 32'(data_out8), 32'h55);
    check("0x55 busy after", 32'(busy8), 32'd0);
    compare_events("0x55");

    // Table of frames, some back-to-back.
    ev_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{dv: vecs[i].exp_dv, fe: vecs[i].exp_fe, data: vecs[i].exp_data});
      send_frame(vecs[i].data, vecs[i].stop, 8);
      check($sformatf("vec%0d data_out", i), 32'(data_out8), 32'(vecs[i].exp_data));
      wait_clk(vecs[i].gap);
      if (vecs[i].gap >= 64) check($sformatf("vec%0d idle", i), 32'(busy8), 32'd0);
    end
    wait_clk(BitClk);
    compare_events("table");

    // Without ticks: start edge still enters START 3 clk later, then nothing advances.
    tick_en = 1'b0;
    wait_clk(2);
    ev_q.delete();
    rx_line = 1'b0;
    wait_clk(2);
    check("notick busy @2", 32'(busy8), 32'd0);
    wait_clk(1);
    check("notick busy @3", 32'(busy8), 32'd1);
    wait_clk(7);
    rx_line = 1'b1;
    wait_clk(200);
    check("notick held", 32'(busy8), 32'd1);
    check("notick no pulse", 32'(ev_q.size()), 32'd0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    tick_en = 1'b1;
    wait_clk(4);
    check("notick rst idle", 32'(busy8), 32'd0);

    // Reset during data bit 4 of 0x3C abandons the frame; 0x81 follows.
    ev_q.delete();
    exp_q.delete();
    begin
      logic [7:0] part;
      part = 8'h3C;
      rx_line = 1'b0;
      wait_clk(BitClk);
      for (int i = 0; i < 4; i++) begin
        rx_line = part[i];
        wait_clk(BitClk);
      end
      rx_line = part[4];
      wait_clk(32);
    end
    check("midrst busy before", 32'(busy8), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    rx_line = 1'b1;
    wait_clk(128);
    check("midrst no pulse", 32'(ev_q.size()), 32'd0);
    check("midrst data_out", 32'(data_out8), 32'd0);
    check("midrst idle", 32'(busy8), 32'd0);
    exp_q.push_back(model_frame(8'h81, 1'b1));
    send_frame(8'h81, 1'b1, 8);
    wait_clk(BitClk);
    check("0x81 data_out", 32'(data_out8), 32'h81);
    compare_events("0x81");

    // Glitch of 3 ticks on the line.
    ev_q.delete();
    rx_line = 1'b0;
    wait_clk(12);
    check("glitch started", 32'(busy8), 32'd1);
    rx_line = 1'b1;
    wait_clk(128);
    check("glitch idle", 32'(busy8), 32'd0);
    check("glitch no pulse", 32'(ev_q.size()), 32'd0);
    check("glitch data_out kept", 32'(data_out8), 32'h81);

    // Break: line held low gives back-to-back framing errors with all-zero data.
    ev_q.delete();
    exp_q.delete();
    exp_q.push_back(model_frame(8'h00, 1'b0));
    exp_q.push_back(model_frame(8'h00, 1'b0));
    rx_line = 1'b0;
    wait_clk(1300);
    rx_line = 1'b1;
    check("break data_out", 32'(data_out8), 32'd0);
    wait_clk(4);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(8);
    compare_events("break");

    // Randomized frames against the frame-level model.
    ev_q.delete();
    exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       stop;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 80)) : 64 + int'($urandom_range(0, 40));
      exp_q.push_back(model_frame(d, stop));
      send_frame(d, stop, 8);
      check($sformatf("rand%0d data_out", n), 32'(data_out8), 32'(d));
      wait_clk(gap);
    end
    wait_clk(BitClk);
    compare_events("rand");

    // 7-bit receiver: stop sampled after half a start bit, 7 data bits and a full stop
    // bit period of ticks, i.e. 8.5 bit periods from the start edge.
    sel7 = 1'b1;
    fork
      send_frame(8'h5A, 1'b1, 7);
      begin
        for (int c = 1; c <= 700; c++) begin
          @(negedge clk);
          if (dv7) begin
            dv7_cnt++;
            if (t7 == 0) t7 = c;
          end
          if (fe7) fe7_cnt++;
        end
      end
    join
    sel7 = 1'b0;
    check_range("db7 dv latency", t7, 544, 547);
    check("db7 dv count", 32'(dv7_cnt), 32'd1);
    check("db7 fe count", 32'(fe7_cnt), 32'd0);
    check("db7 data_out", 32'(data_out7), 32'h5A);
    check("db7 idle", 32'(busy7), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
